// File: rtl/stream_width_packer.sv
// stream_width_packer: narrow-to-wide stream packer.
// Collects RATIO beats of IN_W bits into one IN_W*RATIO-bit word and emits it
// on a registered valid/ready output with a per-lane keep mask. in_last closes
// a partial word early; MSB_FIRST selects whether the first beat fills the
// bottom or the top lane.
module stream_width_packer #(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned RATIO     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned CW    = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc_data;
  logic [RATIO-1:0] acc_keep;

  logic             accept;
  logic             complete;
  int unsigned      lane;
  logic [OUT_W-1:0] merged_data;
  logic [RATIO-1:0] merged_keep;

  // Ready depends only on the output register, so a held word blocks input.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = (cnt == CNT_MAX) || in_last;

  // Accumulator with the incoming beat dropped into its lane; feeds both the
  // accumulator (partial) and the output register (completing beat).
  always_comb begin
    lane        = MSB_FIRST ? (RATIO - 1 - 32'(cnt)) : 32'(cnt);
    merged_data = acc_data;
    merged_keep = acc_keep;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k == lane) begin
        merged_data[k*IN_W +: IN_W] = in_data;
        merged_keep[k]              = 1'b1;
      end
    end
  end

  // Lane counter, accumulator and registered output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          // Completing beat bypasses the accumulator; a same-cycle drain is
          // overridden here so out_valid stays high for back-to-back words.
          out_data  <= merged_data;
          out_keep  <= merged_keep;
          out_last  <= in_last;
          out_valid <= 1'b1;
          acc_data  <= '0;
          acc_keep  <= '0;
          cnt       <= '0;
        end else begin
          acc_data  <= merged_data;
          acc_keep  <= merged_keep;
          cnt       <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_width_packer.sv
// Testbench for stream_width_packer: two instances (LSB-first and MSB-first)
// share one input stream; expected words are queued per instance and a
// monitor per instance pops and compares on every output handshake.
module tb_stream_width_packer;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
  } word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         out_ready;
  logic         in_ready0, in_ready1;
  logic [127:0] od0, od1;
  logic [3:0]   ok0, ok1;
  logic         ol0, ol1;
  logic         ov0, ov1;

  word_t q0[$];
  word_t q1[$];
  int    hs[$];
  bit    cap = 1'b0;
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  int    first_edge;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_width_packer #(.IN_W(32), .RATIO(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready0), .out_data(od0), .out_keep(ok0),
    .out_last(ol0), .out_valid(ov0), .out_ready(out_ready)
  );

  stream_width_packer #(.IN_W(32), .RATIO(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready1), .out_data(od1), .out_keep(ok1),
    .out_last(ol1), .out_valid(ov1), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [127:0] d0, input logic [3:0] k0,
                      input logic [127:0] d1, input logic [3:0] k1, input logic l);
    word_t w;
    w.d = d0; w.k = k0; w.l = l; q0.push_back(w);
    w.d = d1; w.k = k1; w.l = l; q1.push_back(w);
  endtask

  // Present one beat and hold it until both instances have accepted it.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!(in_ready0 && in_ready1) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!(in_ready0 && in_ready1)) begin
      tests++; fails++;
      $display("FAIL send timeout: in_ready=%b/%b required 1", in_ready0, in_ready1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the LSB-first instance.
  always @(negedge clk) begin
    word_t w;
    if (!rst && ov0 && out_ready) begin
      if (cap) hs.push_back(cyc + 1);
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut0 unexpected word: got %h keep %h expected none", od0, ok0);
      end else begin
        w = q0.pop_front();
        check("dut0 out_data", od0, w.d);
        check("dut0 out_keep", 128'(ok0), 128'(w.k));
        check("dut0 out_last", 128'(ol0), 128'(w.l));
      end
    end
  end

  // Monitor for the MSB-first instance.
  always @(negedge clk) begin
    word_t w;
    if (!rst && ov1 && out_ready) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1 unexpected word: got %h keep %h expected none", od1, ok1);
      end else begin
        w = q1.pop_front();
        check("dut1 out_data", od1, w.d);
        check("dut1 out_keep", 128'(ok1), 128'(w.k));
        check("dut1 out_last", 128'(ol1), 128'(w.l));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("reset out_valid", 128'(ov0), 128'(0));
    check("reset out_data",  od0, 128'(0));
    check("reset out_keep",  128'(ok0), 128'(0));
    check("reset out_last",  128'(ol0), 128'(0));
    check("reset in_ready",  128'(in_ready0), 128'(1));
    check("reset dut1 out_valid", 128'(ov1), 128'(0));
    idle(1);
    rst = 1'b0;
    idle(1);

    // Full word, both lane orders; out_valid lasts exactly one cycle
    push(128'h44444444_33333333_22222222_11111111, 4'hF,
         128'h11111111_22222222_33333333_44444444, 4'hF, 1'b0);
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    check("full word out_valid high", 128'(ov0), 128'(1));
    idle(1);
    check("full word out_valid one cycle", 128'(ov0), 128'(0));

    // Two-beat packet closed by in_last
    push(128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 4'h3,
         128'hAAAAAAAA_BBBBBBBB_00000000_00000000, 4'hC, 1'b1);
    send(32'hAAAAAAAA, 1'b0);
    send(32'hBBBBBBBB, 1'b1);

    // Single-beat packet lands in the first lane
    push(128'h00000000_00000000_00000000_CCCCCCCC, 4'h1,
         128'hCCCCCCCC_00000000_00000000_00000000, 4'h8, 1'b1);
    send(32'hCCCCCCCC, 1'b1);

    // in_last on the final lane: full keep with out_last
    push(128'h0000000D_0000000C_0000000B_0000000A, 4'hF,
         128'h0000000A_0000000B_0000000C_0000000D, 4'hF, 1'b1);
    send(32'h0000000A, 1'b0);
    send(32'h0000000B, 1'b0);
    send(32'h0000000C, 1'b0);
    send(32'h0000000D, 1'b1);
    idle(2);

    // Backpressure: word held stable, input blocked, released by out_ready
    out_ready = 1'b0;
    push(128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 4'hF,
         128'hD1D1D1D1_D2D2D2D2_D3D3D3D3_D4D4D4D4, 4'hF, 1'b0);
    send(32'hD1D1D1D1, 1'b0);
    send(32'hD2D2D2D2, 1'b0);
    send(32'hD3D3D3D3, 1'b0);
    send(32'hD4D4D4D4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall out_valid", 128'(ov0), 128'(1));
      check("stall in_ready",  128'(in_ready0), 128'(0));
      check("stall out_data",  od0, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("release in_ready", 128'(in_ready0), 128'(1));
    idle(1);
    check("release drained", 128'(ov0), 128'(0));
    idle(1);

    // Continuous 12 beats with out_ready=1
    push(128'hC0000003_C0000002_C0000001_C0000000, 4'hF,
         128'hC0000000_C0000001_C0000002_C0000003, 4'hF, 1'b0);
    push(128'hC0000007_C0000006_C0000005_C0000004, 4'hF,
         128'hC0000004_C0000005_C0000006_C0000007, 4'hF, 1'b0);
    push(128'hC000000B_C000000A_C0000009_C0000008, 4'hF,
         128'hC0000008_C0000009_C000000A_C000000B, 4'hF, 1'b0);
    hs.delete();
    cap = 1'b1;
    first_edge = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = 32'hC0000000 + 32'(i);
      @(negedge clk);
      if (i == 0) first_edge = cyc + 1;
      check("continuous in_ready", 128'(in_ready0), 128'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(3);
    cap = 1'b0;
    check("continuous word count", 128'(hs.size()), 128'(3));
    for (int k = 0; k < 3; k++) begin
      if (hs.size() > k)
        check("continuous word timing", 128'(hs[k] - first_edge), 128'(4 * (k + 1)));
    end

    // Reset mid-packet discards the partial word
    send(32'hEEEEEEEE, 1'b0);
    send(32'hFFFFFFFF, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midreset out_valid", 128'(ov0), 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push(128'h00000004_00000003_00000002_00000001, 4'hF,
         128'h00000001_00000002_00000003_00000004, 4'hF, 1'b0);
    send(32'h00000001, 1'b0);
    send(32'h00000002, 1'b0);
    send(32'h00000003, 1'b0);
    send(32'h00000004, 1'b0);
    idle(5);

    check("dut0 queue drained", 128'(q0.size()), 128'(0));
    check("dut1 queue drained", 128'(q1.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
